dispatcher_round_robin: RTL and testbench

Credit-based 1-to-N round-robin dispatcher that distributes a single valid/ready input stream across N downstream channels. It is the counterpart to the N-to-1 round-robin arbiter: the arbiter merges many requesters onto one resource, and this block fans one producer out to many consumers. Each consumer advertises buffer space through credit-return pulses. The block emits one registered, one-hot-targeted beat per accepted input.

---
 rtl/dispatcher_round_robin.sv | 143 ++++++++++++++
 tb/tb_dispatcher_round_robin.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dispatcher_round_robin.sv
// dispatcher_round_robin
// Fans a single valid/ready stream out to N consumers in round-robin order.
// Each consumer owns CRED buffer slots. A beat is sent only to a channel that
// holds at least one credit, and the consumer hands credits back with
// one-cycle pulses on credit_return. The output beat is registered and its
// target is marked by a one-hot out_valid strobe.
module dispatcher_round_robin #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int CRED = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic [N-1:0] out_valid,
  output logic [W-1:0] out_data,
  input  logic [N-1:0] credit_return,
  output logic         credit_err
);

  localparam int CW = $clog2(CRED + 1);
  localparam int PW = $clog2(N);

  localparam logic [CW-1:0] CredMax  = CW'(CRED);
  localparam logic [PW-1:0] PtrReset = PW'(N - 1);

  logic [CW-1:0] creditCnt_q [N];
  logic [CW-1:0] creditCnt_d [N];
  logic [PW-1:0] lastGrant_q;
  logic [PW-1:0] lastGrant_d;
  logic [N-1:0]  outValid_q;
  logic [N-1:0]  outValid_d;
  logic [W-1:0]  outData_q;
  logic [W-1:0]  outData_d;
  logic          creditErr_q;
  logic          creditErr_d;

  logic [N-1:0]  eligible;
  logic [N-1:0]  aboveMask;
  logic [N-1:0]  maskedReq;
  logic [N-1:0]  pickReq;
  logic [PW-1:0] selIdx;
  logic [N-1:0]  selOneHot;
  logic          dispatch;

  // A channel is eligible only while its registered counter is nonzero.
  // Because of this, a credit returned this cycle becomes usable in the next cycle.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N; i++) begin
      eligible[i] = (creditCnt_q[i] != '0);
    end
  end

  assign in_ready = |eligible;
  assign dispatch = in_valid & in_ready;

  // Build the mask of channels strictly above the last grant. The round-robin
  // search therefore starts at ptr+1.
  always_comb begin
    aboveMask = '0;
    for (int i = 0; i < N; i++) begin
      aboveMask[i] = (PW'(i) > lastGrant_q);
    end
  end

  assign maskedReq = eligible & aboveMask;
  assign pickReq   = (|maskedReq) ? maskedReq : eligible;

  // Find the lowest set bit of the chosen request vector. Scanning from the top
  // down lets the lowest index overwrite the result last.
  always_comb begin
    selIdx    = '0;
    selOneHot = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pickReq[i]) begin
        selIdx    = PW'(i);
        selOneHot = '0;
        selOneHot[i] = 1'b1;
      end
    end
  end

  // Compute the next state. A dispatch and a return on the same channel
  // cancel each other. A return to a channel that is already full saturates
  // the counter and raises the sticky error flag.
  always_comb begin
    lastGrant_d = lastGrant_q;
    outValid_d  = '0;
    outData_d   = outData_q;
    creditErr_d = creditErr_q;
    for (int i = 0; i < N; i++) begin
      creditCnt_d[i] = creditCnt_q[i];
    end

    if (dispatch) begin
      outValid_d  = selOneHot;
      outData_d   = in_data;
      lastGrant_d = selIdx;
    end

    for (int i = 0; i < N; i++) begin
      if (dispatch && selOneHot[i] && !credit_return[i]) begin
        creditCnt_d[i] = creditCnt_q[i] - 1'b1;
      end else if (credit_return[i] && !(dispatch && selOneHot[i])) begin
        if (creditCnt_q[i] == CredMax) begin
          creditErr_d = 1'b1;
        end else begin
          creditCnt_d[i] = creditCnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Register the state. Reset has priority over dispatch and credit returns,
  // so any beat presented while rst is high is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        creditCnt_q[i] <= CredMax;
      end
      lastGrant_q <= PtrReset;
      outValid_q  <= '0;
      outData_q   <= '0;
      creditErr_q <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        creditCnt_q[i] <= creditCnt_d[i];
      end
      lastGrant_q <= lastGrant_d;
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
      creditErr_q <= creditErr_d;
    end
  end

  assign out_valid  = outValid_q;
  assign out_data   = outData_q;
  assign credit_err = creditErr_q;

endmodule

// File: tb/tb_dispatcher_round_robin.sv
// Testbench for dispatcher_round_robin (N=4, W=8, CRED=2).
// Stimulus comes from a vector table. Expected beats are queued when a beat
// is driven and are compared on the following cycle.
module tb_dispatcher_round_robin;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] out_valid;
  logic [7:0] out_data;
  logic [3:0] credit_return;
  logic       credit_err;

  int passCount;
  int totalCount;

  typedef struct {
    logic       inValid;
    logic [7:0] inData;
    logic [3:0] creditRet;
    logic       expReady;
    logic [3:0] expTarget;
  } vecT;

  typedef struct {
    logic [3:0] target;
    logic [7:0] data;
  } beatT;

  vecT  tbl[$];
  beatT scoreboard[$];

  dispatcher_round_robin #(.N(4), .W(8), .CRED(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .credit_return (credit_return),
    .credit_err    (credit_err)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Backstop so that the simulation can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one value and update the pass and total counters.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare the registered output against the oldest queued beat.
  // When no beat is queued, the outputs must be idle.
  task automatic checkOutput();
    beatT b;
    if (scoreboard.size() > 0) begin
      b = scoreboard.pop_front();
      check("out_valid", {28'd0, out_valid}, {28'd0, b.target});
      check("out_data", {24'd0, out_data}, {24'd0, b.data});
    end else begin
      check("out_valid idle", {28'd0, out_valid}, 32'd0);
    end
  endtask

  // Drive one cycle of inputs and check in_ready before the edge.
  // Queue the expected beat, then check the output just after the edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [3:0] cr,
                               input logic expReady, input logic [3:0] expTarget);
    @(negedge clk);
    in_valid      = v;
    in_data       = d;
    credit_return = cr;
    #1;
    check("in_ready", {31'd0, in_ready}, {31'd0, expReady});
    if (expTarget != 4'b0000) begin
      scoreboard.push_back('{expTarget, d});
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Check all four credit counters against one expected value.
  task automatic checkCounters(input logic [1:0] exp);
    for (int i = 0; i < 4; i++) begin
      check("cnt", {30'd0, dut.creditCnt_q[i]}, {30'd0, exp});
    end
  endtask

  initial begin
    passCount     = 0;
    totalCount    = 0;
    rst           = 1'b1;
    in_valid      = 1'b0;
    in_data       = 8'h00;
    credit_return = 4'b0000;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset out_valid", {28'd0, out_valid}, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset credit_err", {31'd0, credit_err}, 32'd0);
    checkCounters(2'd2);

    // Rotation and exhaustion: 8 beats are accepted, then beats 9 and 10 are held off
    for (int k = 0; k < 10; k++) begin
      if (k < 8) tbl.push_back('{1'b1, 8'h10 + 8'(k), 4'b0000, 1'b1, 4'b0001 << (k % 4)});
      else       tbl.push_back('{1'b1, 8'h10 + 8'(k), 4'b0000, 1'b0, 4'b0000});
    end
    // Skip and wrap: refill channels 0 and 3 with ptr=3, then expect targets 0,3,0,3
    tbl.push_back('{1'b0, 8'h00, 4'b1001, 1'b0, 4'b0000});
    tbl.push_back('{1'b0, 8'h00, 4'b1001, 1'b1, 4'b0000});
    tbl.push_back('{1'b1, 8'h20, 4'b0000, 1'b1, 4'b0001});
    tbl.push_back('{1'b1, 8'h21, 4'b0000, 1'b1, 4'b1000});
    tbl.push_back('{1'b1, 8'h22, 4'b0000, 1'b1, 4'b0001});
    tbl.push_back('{1'b1, 8'h23, 4'b0000, 1'b1, 4'b1000});
    tbl.push_back('{1'b1, 8'h24, 4'b0000, 1'b0, 4'b0000});
    // Full stall recovery: a credit returned to channel 2 is usable on the next cycle only
    tbl.push_back('{1'b1, 8'h30, 4'b0100, 1'b0, 4'b0000});
    tbl.push_back('{1'b1, 8'h31, 4'b0000, 1'b1, 4'b0100});
    tbl.push_back('{1'b1, 8'h32, 4'b0000, 1'b0, 4'b0000});

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].inValid, tbl[i].inData, tbl[i].creditRet,
                    tbl[i].expReady, tbl[i].expTarget);
    end

    // Same-cycle dispatch and return on channel 0 while cnt[0]=1
    applyStimulus(1'b0, 8'h00, 4'b0001, 1'b0, 4'b0000);
    check("cnt0 before collision", {30'd0, dut.creditCnt_q[0]}, 32'd1);
    applyStimulus(1'b1, 8'h40, 4'b0001, 1'b1, 4'b0001);
    check("cnt0 after collision", {30'd0, dut.creditCnt_q[0]}, 32'd1);
    check("no err on collision", {31'd0, credit_err}, 32'd0);

    // Overflow: fill channel 0 to CRED, then return one more credit
    applyStimulus(1'b0, 8'h00, 4'b0001, 1'b1, 4'b0000);
    check("cnt0 full", {30'd0, dut.creditCnt_q[0]}, 32'd2);
    check("no err at full", {31'd0, credit_err}, 32'd0);
    applyStimulus(1'b0, 8'h00, 4'b0001, 1'b1, 4'b0000);
    check("cnt0 saturated", {30'd0, dut.creditCnt_q[0]}, 32'd2);
    check("credit_err set", {31'd0, credit_err}, 32'd1);
    applyStimulus(1'b0, 8'h00, 4'b0000, 1'b1, 4'b0000);
    check("credit_err sticky", {31'd0, credit_err}, 32'd1);

    // Mid-stream reset: the beat presented during reset is dropped
    applyStimulus(1'b1, 8'h50, 4'b0000, 1'b1, 4'b0001);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h51;
    @(posedge clk);
    #1;
    check("mid reset out_valid", {28'd0, out_valid}, 32'd0);
    check("mid reset credit_err", {31'd0, credit_err}, 32'd0);
    check("mid reset in_ready", {31'd0, in_ready}, 32'd1);
    checkCounters(2'd2);
    rst = 1'b0;
    applyStimulus(1'b1, 8'h52, 4'b0000, 1'b1, 4'b0001);
    applyStimulus(1'b1, 8'h53, 4'b0000, 1'b1, 4'b0010);
    applyStimulus(1'b0, 8'h00, 4'b0000, 1'b1, 4'b0000);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
